id_ex_pipe: RTL
===============

// Module: id_ex_pipe
// PURPOSE
//  Decode-to-execute pipeline register feeding the ALU: latches register operands, builds the immediate, selects operand B,
//  derives ALUsel and control bits, and forwards a result from the EX/MEM stage. Elastic valid/ready stage with stall and flush.
// PARAMETERS
//  DATA_W      32  operand/result width
//  REG_AW      5   register-file address width
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        decode presents an instruction
//  in_ready    out  1        stage accepts this cycle
//  opcode      in   6        instr[31:26]
//  funct       in   6        instr[5:0]
//  imm16       in   16       instr[15:0]
//  rs_addr     in   REG_AW   instr[25:21]
//  rt_addr     in   REG_AW   instr[20:16]
//  rd_addr     in   REG_AW   instr[15:11]
//  rs_data     in   DATA_W   register file read port 1
//  rt_data     in   DATA_W   register file read port 2
//  flush       in   1        kill the held and incoming instruction (branch taken)
//  fwd_en      in   1        EX/MEM result valid for forwarding
//  fwd_addr    in   REG_AW   EX/MEM destination register
//  fwd_data    in   DATA_W   EX/MEM result
//  out_valid   out  1        registered outputs hold a live instruction
//  out_ready   in   1        ALU stage consumes this cycle
//  A           out  DATA_W   ALU operand A
//  B           out  DATA_W   ALU operand B
//  ALUsel      out  6        ALU operation select
//  StoreData   out  DATA_W   rt value for sw
//  DestReg     out  REG_AW   write-back register
//  RegWrite    out  1        write-back enable
//  MemRead     out  1        lw
//  MemWrite    out  1        sw
//  Illegal     out  1        unsupported opcode/funct captured
// BEHAVIOUR
//  - Reset: out_valid and every data/control output = 0. Takes effect on the next rising edge and overrides flush and load.
//  - in_ready = !out_valid | out_ready (combinational). Load when in_valid & in_ready. Latency: 1 cycle.
//  - Otherwise, if out_ready is high, out_valid <= 0. If out_ready is low, hold all outputs unchanged (stall).
//  - flush: out_valid <= 0 next edge, takes priority over load. Data outputs and control bits are zeroed.
//  - ALUsel = (opcode==6'b000000) ? funct : opcode.
//  - R-type (add 100000, sub 100010, or 100101, and 100100, slt 101010):
//    B = rt value, DestReg = rd_addr, RegWrite = 1.
//  - addi 001000: imm16 is sign-extended. ori 001101 and andi 001100: imm16 is zero-extended.
//    B = extended imm, DestReg = rt_addr, RegWrite = 1.
//  - lw 100011: B = sext(imm16), DestReg = rt_addr, RegWrite = 1, MemRead = 1.
//  - sw 101011: B = sext(imm16), StoreData = rt value, MemWrite = 1.
//  - beq 000100 / bne 000101: B = rt value, no write-back.
//  - Any other opcode/funct: Illegal = 1, ALUsel = 0, RegWrite, MemRead and MemWrite all 0; out_valid is still set.
//  - DestReg == 0 forces RegWrite = 0.
//  - All decode is registered at load; no output is combinational from an input except in_ready.
// CONFIGURATION
//  ID_EX_FORWARD_EN defined:
//    rs value = fwd_data when fwd_en & fwd_addr!=0 & fwd_addr==rs_addr, else rs_data; same rule for rt.
//    Both operands may forward in the same cycle.
//  ID_EX_FORWARD_EN undefined:
//    fwd_* ports remain on the interface but are ignored; rs_data and rt_data are used directly.
// STRUCTURE
//  - Package mips_pkg:
//    opcode constants (OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE);
//    funct constants (FN_ADD, FN_SUB, FN_OR, FN_AND, FN_SLT);
//    ctrl_t typedef {RegWrite, MemRead, MemWrite, Illegal, use_imm, zext}.
//  - Sub-module alu_sel_decode (combinational):
//    opcode/funct -> ALUsel plus ctrl_t. The register stage, operand mux and forwarding stay in id_ex_pipe.
// TESTING
//  1. rst high 2 cycles with in_valid=1 -> out_valid=0, A=B=0, RegWrite=0, in_ready=1.
//  2. add r3,r1,r2 (rs_data=5, rt_data=7) with out_ready=1 -> next cycle A=5, B=7, ALUsel=100000, DestReg=3, RegWrite=1.
//  3. addi imm16=16'hFFFF -> B=32'hFFFFFFFF; ori imm16=16'hFFFF -> B=32'h0000FFFF; sw imm16=16'h0004, rt_data=9
//     -> B=4, StoreData=9, MemWrite=1, RegWrite=0.
//  4. out_ready=0 for 3 cycles with new in_valid instructions -> in_ready=0 and outputs stable.
//     When out_ready rises, the pending instruction loads on the next edge.
//  5. flush and in_valid together -> out_valid=0 next cycle, RegWrite=0.
//     A subsequent load proceeds normally.
//  6. With ID_EX_FORWARD_EN: fwd_en=1, fwd_addr=1, fwd_data=42, rs_addr=rt_addr=1 -> A=B=42.
//     fwd_addr=0 -> no forwarding. Without the macro -> A = rs_data.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared MIPS decode definitions for the ID/EX stage.
//   - Opcode constants (instr[31:26]) and R-type funct constants (instr[5:0]).
//   - ctrl_t : decoded control bundle produced by alu_sel_decode.
//   - sext16 / zext16 : immediate extension helpers.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // RegWrite here is the opcode's intent; the stage still clears it when
    // the destination register turns out to be r0.
    typedef struct packed {
        logic RegWrite;
        logic MemRead;
        logic MemWrite;
        logic Illegal;
        logic use_imm;   // operand B comes from the immediate, not rt
        logic zext;      // immediate is zero-extended (logical ops)
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        logic signed [15:0] simm;
        simm = signed'(imm);
        return 32'(simm);
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_sel_decode.sv
// -----------------------------------------------------------------------------
// alu_sel_decode
//   Purely combinational opcode/funct decoder.
//   Ports:
//     opcode  in  [5:0]  instr[31:26]
//     funct   in  [5:0]  instr[5:0]
//     alu_sel out [5:0]  ALU operation (funct for R-type, opcode otherwise,
//                        0 for anything unsupported)
//     ctrl    out ctrl_t control bundle for the ID/EX register
// -----------------------------------------------------------------------------
module alu_sel_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [5:0] alu_sel,
    output ctrl_t      ctrl
);

    always_comb begin
        alu_sel = 6'b000000;
        ctrl    = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_OR, FN_AND, FN_SLT: begin
                        alu_sel       = funct;
                        ctrl.RegWrite = 1'b1;
                    end
                    default: ctrl.Illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_sel       = opcode;
                ctrl.RegWrite = 1'b1;
                ctrl.use_imm  = 1'b1;
            end
            OP_ORI, OP_ANDI: begin
                alu_sel       = opcode;
                ctrl.RegWrite = 1'b1;
                ctrl.use_imm  = 1'b1;
                ctrl.zext     = 1'b1;
            end
            OP_LW: begin
                alu_sel       = opcode;
                ctrl.RegWrite = 1'b1;
                ctrl.MemRead  = 1'b1;
                ctrl.use_imm  = 1'b1;
            end
            OP_SW: begin
                alu_sel       = opcode;
                ctrl.MemWrite = 1'b1;
                ctrl.use_imm  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // Compare rs against rt; nothing written back.
                alu_sel = opcode;
            end
            default: ctrl.Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//   Decode-to-execute pipeline register. Latches register operands, builds the
//   immediate, selects operand B, registers ALUsel and control bits, and
//   (optionally) forwards the EX/MEM result into the rs/rt operands.
//   Elastic valid/ready handshake on both sides, with stall and flush.
//
//   Build option: define ID_EX_FORWARD_EN to enable EX/MEM forwarding.
//   Without it the fwd_* ports remain but are ignored.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid / in_ready      upstream handshake (in_ready combinational)
//     opcode, funct, imm16     instruction fields
//     rs_addr, rt_addr, rd_addr register addresses
//     rs_data, rt_data         register file read data
//     flush                    kill held and incoming instruction
//     fwd_en/fwd_addr/fwd_data EX/MEM forwarding source
//     out_valid / out_ready    downstream handshake
//     A, B, ALUsel, StoreData, DestReg, RegWrite, MemRead, MemWrite, Illegal
//                              registered ALU-stage outputs
// -----------------------------------------------------------------------------
module id_ex_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm16,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    input  logic              fwd_en,
    input  logic [REG_AW-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [5:0]        ALUsel,
    output logic [DATA_W-1:0] StoreData,
    output logic [REG_AW-1:0] DestReg,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Illegal
);

    // ---------------- decode (combinational, registered below) -------------
    logic [5:0] dec_alu_sel;
    ctrl_t      dec_ctrl;

    alu_sel_decode u_dec (
        .opcode (opcode),
        .funct  (funct),
        .alu_sel(dec_alu_sel),
        .ctrl   (dec_ctrl)
    );

    // ---------------- operand sourcing ------------------------------------
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

`ifdef ID_EX_FORWARD_EN
    // r0 is hard-wired to zero, so a pending write to it must never forward.
    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
        if (fwd_en && (fwd_addr != '0) && (fwd_addr == rs_addr)) rs_val = fwd_data;
        if (fwd_en && (fwd_addr != '0) && (fwd_addr == rt_addr)) rt_val = fwd_data;
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^{fwd_en, fwd_addr, fwd_data, rs_addr};
    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
    end
`endif

    logic [31:0]       imm_ext32;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_sel;
    logic [REG_AW-1:0] dest_sel;
    logic              reg_write_sel;
    logic [DATA_W-1:0] store_sel;

    always_comb begin
        imm_ext32 = dec_ctrl.zext ? zext16(imm16) : sext16(imm16);
        imm_ext   = DATA_W'(imm_ext32);
        b_sel     = dec_ctrl.use_imm ? imm_ext : rt_val;
        store_sel = dec_ctrl.MemWrite ? rt_val : '0;

        // R-type writes rd, I-type writers write rt, everything else none.
        dest_sel = '0;
        if (dec_ctrl.RegWrite) begin
            dest_sel = (opcode == OP_RTYPE) ? rd_addr : rt_addr;
        end
        reg_write_sel = dec_ctrl.RegWrite && (dest_sel != '0);
    end

    // ---------------- handshake -------------------------------------------
    logic valid_q, valid_d;
    logic load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // ---------------- ID/EX register --------------------------------------
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [5:0]        alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              illegal_q, illegal_d;

    always_comb begin
        valid_d     = valid_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_sel_d   = alu_sel_q;
        store_d     = store_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        illegal_d   = illegal_q;

        if (flush) begin
            valid_d     = 1'b0;
            a_d         = '0;
            b_d         = '0;
            alu_sel_d   = '0;
            store_d     = '0;
            dest_d      = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (load) begin
            valid_d     = 1'b1;
            a_d         = rs_val;
            b_d         = b_sel;
            alu_sel_d   = dec_alu_sel;
            store_d     = store_sel;
            dest_d      = dest_sel;
            reg_write_d = reg_write_sel;
            mem_read_d  = dec_ctrl.MemRead;
            mem_write_d = dec_ctrl.MemWrite;
            illegal_d   = dec_ctrl.Illegal;
        end else if (out_ready) begin
            // Consumed with nothing behind it; data is left as-is.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alu_sel_q   <= '0;
            store_q     <= '0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_sel_q   <= alu_sel_d;
            store_q     <= store_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = valid_q;
    assign A         = a_q;
    assign B         = b_q;
    assign ALUsel    = alu_sel_q;
    assign StoreData = store_q;
    assign DestReg   = dest_q;
    assign RegWrite  = reg_write_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;
    assign Illegal   = illegal_q;

endmodule
